cla20_result_collector: RTL and testbench

- Downstream stage of the 20-bit pipelined CLA adder. Captures the adder's sum and carry-out for each issued operation and queues them in a small FIFO. Results leave through a valid/ready interface.
- The adder itself has no valid tracking and no backpressure. This block adds both:
  - a valid delay line matched to the adder latency, so it knows which adder outputs are real results;
  - credit-based issue control, so the upstream source never launches an operation whose result has no FIFO slot.

---
 rtl/cla20_result_collector.sv | 131 +++++++++++++
 tb/tb_cla20_result_collector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla20_result_collector.sv
// Result collector for the 20-bit pipelined CLA adder.
// Tracks which adder outputs are real results with a valid delay line
// matched to the adder latency. Queues sum/carry pairs in a show-ahead
// FIFO. Throttles upstream issue with a credit counter so that every
// launched operation is guaranteed a FIFO slot.
module cla20_result_collector #(
    parameter int W       = 20,
    parameter int LATENCY = 7,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [W-1:0]     adder_s,
    input  logic             adder_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_cout,
    output logic [CNT_W-1:0] fifo_count,
    output logic             drop_err
);

    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [LATENCY-1:0] vld_p;
    logic               tap;
    logic               acc;
    logic               push;
    logic               pop;
    logic               full;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   occ;
    logic [W:0]         mem [DEPTH];
    logic [W:0]         head;

    // Credits come from registered occupancy only, so out_ready never
    // reaches issue_ready combinationally; a pop frees its credit next cycle.
    assign issue_ready = (occ < DEPTH_C);
    assign acc         = issue_valid & issue_ready;

    // Tap aligns with the adder output of the op accepted LATENCY edges ago.
    assign tap  = vld_p[LATENCY-1];
    assign full = (fifo_count == DEPTH_C);
    // A push into a full FIFO cannot happen while credits are honoured;
    // if it ever does, the write is dropped and pointers stay put.
    assign push = tap & ~full;

    // Show-ahead head; data is masked to zero while the FIFO is empty.
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;
    assign head      = mem[rd_ptr];
    assign out_sum   = out_valid ? head[W-1:0] : '0;
    assign out_cout  = out_valid & head[W];

    // Valid delay line: one bit per adder stage, shifted every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p <= (vld_p << 1) | LATENCY'(acc);
        end
    end

    // Result storage: data path only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {adder_cout, adder_s};
        end
    end

    // FIFO pointers and stored-result count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Credit counter: in-flight ops plus stored results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            case ({acc, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Sticky flag for issues offered while no credit was available.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
        end else if (issue_valid && !issue_ready) begin
            drop_err <= 1'b1;
        end
    end

    ap_no_overflow_push: assert property (
        @(posedge clk) disable iff (!rst_n) !(tap && full)
    ) else $error("collector: result arrived with FIFO full");

    ap_occ_bound: assert property (
        @(posedge clk) disable iff (!rst_n) (occ <= DEPTH_C)
    ) else $error("collector: credit counter above DEPTH");

    ap_count_le_occ: assert property (
        @(posedge clk) disable iff (!rst_n) (fifo_count <= occ)
    ) else $error("collector: stored count exceeds credit count");

endmodule

// File: tb/tb_cla20_result_collector.sv
// Directed bench for cla20_result_collector with a latency-7 adder model.
module tb_cla20_result_collector;

    localparam int W     = 20;
    localparam int LAT   = 7;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             issue_valid;
    logic             issue_ready;
    logic [W-1:0]     adder_s;
    logic             adder_cout;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
    logic             out_cout;
    logic [CNT_W-1:0] fifo_count;
    logic             drop_err;

    logic [W-1:0] a, b;
    logic         cin;
    logic [W:0]   apipe [LAT];
    logic [W:0]   exp_q [$];
    logic [W:0]   head_obs;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    // Adder model: same latency as the real CLA, free-running.
    always @(posedge clk) begin
        apipe[0] <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign adder_s    = apipe[LAT-1][W-1:0];
    assign adder_cout = apipe[LAT-1][W];
    assign head_obs   = {out_cout, out_sum};

    cla20_result_collector #(.W(W), .LATENCY(LAT), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .adder_s    (adder_s),
        .adder_cout (adder_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .fifo_count (fifo_count),
        .drop_err   (drop_err)
    );

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a = x; b = y; cin = c; issue_valid = 1'b1;
        if (issue_ready) exp_q.push_back(model(x, y, c));
        tick();
        issue_valid = 1'b0;
    endtask

    initial begin
        logic       rdy [10];
        int         accepts;
        int         issued;
        int         got;
        int         waited;
        logic [W:0] e;

        rst_n = 1'b0; issue_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_drop_err", 32'(drop_err), 32'd0);
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Single op: accepted on edge 0, adder result at edge 6, FIFO write at edge 7
        out_ready = 1'b1;
        a = 20'h06F77; b = 20'h07178; cin = 1'b0; issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6) check("t1_not_yet_valid", 32'(out_valid), 32'd0);
        end
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_sum", 32'(out_sum), 32'h0E0EF);
        check("t1_cout", 32'(out_cout), 32'd0);
        tick();
        check("t1_valid_drop", 32'(out_valid), 32'd0);

        // Carry-out case followed by carry-in case, in order
        out_ready = 1'b0;
        issue(20'hFFFFF, 20'h00001, 1'b0);
        issue(20'h00001, 20'h06003, 1'b1);
        repeat (7) tick();
        check("t2_count", 32'(fifo_count), 32'd2);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_sum0", 32'(out_sum), 32'h00000);
        check("t2_cout0", 32'(out_cout), 32'd1);
        out_ready = 1'b1;
        tick();
        check("t2_sum1", 32'(out_sum), 32'h06005);
        check("t2_cout1", 32'(out_cout), 32'd0);
        tick();
        check("t2_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        exp_q.delete();
        check("t2_drop_err_clear", 32'(drop_err), 32'd0);

        // Backpressure: 10 offered, 8 accepted
        accepts = 0;
        for (int k = 0; k < 10; k++) begin
            a = W'(32'h10000 + k * 32'h111); b = W'(32'h00F00 + k); cin = k[0];
            issue_valid = 1'b1;
            rdy[k] = issue_ready;
            if (issue_ready) begin
                exp_q.push_back(model(a, b, cin));
                accepts++;
            end
            tick();
        end
        issue_valid = 1'b0;
        check("t3_accepts", 32'(accepts), 32'd8);
        check("t3_ready_8th", 32'(rdy[7]), 32'd1);
        check("t3_ready_9th", 32'(rdy[8]), 32'd0);
        check("t3_drop_err", 32'(drop_err), 32'd1);
        repeat (10) tick();
        check("t3_count_full", 32'(fifo_count), 32'd8);
        check("t3_no_credit", 32'(issue_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            check("t3_head", 32'(head_obs), 32'(e));
            tick();
            if (k == 0) check("t3_credit_back", 32'(issue_ready), 32'd1);
        end
        check("t3_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Drain/refill with wrap-around, out_ready toggling
        issued = 0; got = 0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            out_ready = (cyc % 2 == 0);
            if (issued < 20) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                issue_valid = 1'b1;
            end else begin
                issue_valid = 1'b0;
            end
            if (issue_valid && issue_ready) begin
                exp_q.push_back(model(a, b, cin));
                issued++;
            end
            if (out_valid && out_ready) begin
                check("t4_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                check("t4_head", 32'(head_obs), 32'(e));
                got++;
            end
            check("t4_count_bound", 32'(fifo_count <= CNT_W'(DEPTH)), 32'd1);
            tick();
        end
        issue_valid = 1'b0; out_ready = 1'b0;
        check("t4_all_results", 32'(got), 32'd20);
        check("t4_empty", 32'(out_valid), 32'd0);
        exp_q.delete();

        // Simultaneous push and pop at fifo_count = 3
        for (int k = 0; k < 4; k++) issue(W'(32'h20000 + k * 32'h1001), W'(32'h00123 * (k + 1)), 1'b0);
        repeat (6) tick();
        check("t5_count3", 32'(fifo_count), 32'd3);
        check("t5_head0", 32'(head_obs), 32'(exp_q[0]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        check("t5_count_hold", 32'(fifo_count), 32'd3);
        check("t5_head1", 32'(head_obs), 32'(exp_q[0]));
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            check("t5_drain", 32'(head_obs), 32'(e));
            tick();
        end
        out_ready = 1'b0;
        check("t5_empty", 32'(out_valid), 32'd0);
        exp_q.delete();

        // Reset mid-flight: 2 stored, 4 in flight
        for (int k = 0; k < 6; k++) issue(W'(32'h30000 + k), W'(32'h00055), 1'b0);
        repeat (3) tick();
        check("t6_count2", 32'(fifo_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(out_valid), 32'd0);
        check("t6_async_count", 32'(fifo_count), 32'd0);
        check("t6_async_drop_err", 32'(drop_err), 32'd0);
        check("t6_async_sum", 32'(out_sum), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t6_ready_after_rst", 32'(issue_ready), 32'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t6_no_stale", 32'(out_valid), 32'd0);
        end
        exp_q.delete();
        issue(20'h12345, 20'h00ABC, 1'b1);
        waited = 0;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        check("t6_new_latency", 32'(waited), 32'd7);
        check("t6_new_sum", 32'(out_sum), 32'h12E02);
        check("t6_new_cout", 32'(out_cout), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
